// File: rtl/jru_pkg.sv
// Shared definitions for the jump/branch resolution unit: funct3 classes,
// branch-pipe control entry and decode helpers.
package jru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JAL  = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Control half of a pipe entry; the XLEN-wide target travels alongside it.
    typedef struct packed {
        logic       valid;
        logic [2:0] br_type;
    } br_ctrl_t;

    function automatic logic is_jump(input logic [2:0] funct3);
        return (funct3 == F3_JAL) || (funct3 == F3_JALR);
    endfunction

    function automatic logic br_cond(input logic [2:0] funct3, input logic zero,
                                     input logic bit_c);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = !zero;
            F3_BLT, F3_BLTU:  taken = bit_c;
            F3_BGE, F3_BGEU:  taken = !bit_c;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/jru_branch_pipe.sv
// BR_DEPTH-deep shift pipe of in-flight conditional branches; entry 0 is the
// youngest, entry BR_DEPTH-1 is the tail whose condition is evaluated.
module jru_branch_pipe
    import jru_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BR_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enq,
    input  logic            squash,
    input  logic [2:0]      enq_type,
    input  logic [XLEN-1:0] enq_target,
    output logic            any_valid,
    output br_ctrl_t        tail_ctrl,
    output logic [XLEN-1:0] tail_target
);

    br_ctrl_t        ctrl_q   [BR_DEPTH];
    logic [XLEN-1:0] target_q [BR_DEPTH];

    // NOTE: targets are reset along with valids so newPC reads 0 after reset
    // instead of stale addresses from the discarded branches.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BR_DEPTH; i++) begin
                ctrl_q[i]   <= '0;
                target_q[i] <= '0;
            end
        end else begin
            ctrl_q[0].valid   <= enq && !squash;
            ctrl_q[0].br_type <= enq_type;
            target_q[0]       <= enq_target;
            for (int i = 1; i < BR_DEPTH; i++) begin
                ctrl_q[i].valid   <= ctrl_q[i-1].valid && !squash;
                ctrl_q[i].br_type <= ctrl_q[i-1].br_type;
                target_q[i]       <= target_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < BR_DEPTH; i++) begin
            any_valid = any_valid | ctrl_q[i].valid;
        end
    end

    assign tail_ctrl   = ctrl_q[BR_DEPTH-1];
    assign tail_target = target_q[BR_DEPTH-1];

endmodule

// File: rtl/jump_resolve_unit.sv
// Branch/jump resolution beside execute: fetch redirect, flush pulses, decoder stall.
// Optional misaligned-target trapping is enabled by defining JRU_MISALIGN_TRAP_EN.
module jump_resolve_unit
    import jru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BR_DEPTH  = 2,
    parameter int HAZ_DEPTH = 2,
    parameter int REG_AW    = 6,
    parameter int PC_OFFSET = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              new_jmp,
    input  logic [2:0]        jmp_type,
    input  logic [REG_AW-1:0] jal_rs,
    input  logic [XLEN-1:0]   busJ,
    input  logic [REG_AW-1:0] rd,
    input  logic              bit_bus_C,
    input  logic              zero,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   newPC,
    output logic              ctrlFetch,
    output logic              reset_branch,
    output logic              reset_jal,
    output logic              halt,
    output logic              misalign_trap,
    output logic [XLEN-1:0]   misalign_addr
);

    logic [REG_AW-1:0] hist_q [HAZ_DEPTH];
    br_ctrl_t          tail_ctrl;
    logic [XLEN-1:0]   tail_target;
    logic [XLEN-1:0]   jmp_target;
    logic [XLEN-1:0]   sel_target;
    logic              any_valid;
    logic              jmp_issue;
    logic              jump_go;
    logic              br_taken;
    logic              rs_hit;
    logic              misaligned;

    jru_branch_pipe #(
        .XLEN     (XLEN),
        .BR_DEPTH (BR_DEPTH)
    ) u_pipe (
        .clock       (clock),
        .reset       (reset),
        .enq         (!reset && new_jmp && !is_jump(jmp_type)),
        .squash      (br_taken),
        .enq_type    (jmp_type),
        .enq_target  (pc + imm - XLEN'(PC_OFFSET)),
        .any_valid   (any_valid),
        .tail_ctrl   (tail_ctrl),
        .tail_target (tail_target)
    );

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (jal_rs != '0 && hist_q[i] == jal_rs) rs_hit = 1'b1;
        end
    end

    // Reset gating keeps in-flight branches from redirecting while being discarded.
    assign br_taken  = !reset && tail_ctrl.valid && br_cond(tail_ctrl.br_type, zero, bit_bus_C);
    assign jmp_issue = !reset && new_jmp && is_jump(jmp_type);
    assign halt      = jmp_issue && (any_valid || rs_hit);
    assign jump_go   = jmp_issue && !halt;

`ifdef JRU_MISALIGN_TRAP_EN
    assign jmp_target = busJ + imm;
`else
    assign jmp_target = (jmp_type == F3_JALR) ? ((busJ + imm) & ~XLEN'(1)) : (busJ + imm);
`endif

    assign sel_target = (br_taken || !jump_go) ? tail_target : jmp_target;

`ifdef JRU_MISALIGN_TRAP_EN
    assign misaligned = (br_taken || jump_go) && (sel_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_trap <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_trap <= misaligned;
            if (misaligned) misalign_addr <= sel_target;
        end
    end
`else
    assign misaligned    = 1'b0;
    assign misalign_trap = 1'b0;
    assign misalign_addr = '0;
`endif

    assign newPC     = sel_target;
    assign ctrlFetch = (br_taken || jump_go) && !misaligned;

    // NOTE: state registers use non-blocking assignments so the shift reads old values.
    always_ff @(posedge clock) begin
        if (reset || br_taken) begin
            for (int i = 0; i < HAZ_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            hist_q[0] <= jump_go ? rd : '0;
            for (int i = 1; i < HAZ_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    // Flush pulses sample mid-cycle so the downstream stages see them before the next edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            reset_branch <= 1'b0;
            reset_jal    <= 1'b0;
        end else begin
            reset_branch <= br_taken && !misaligned;
            reset_jal    <= jump_go && !misaligned;
        end
    end

endmodule

// File: doc/jump_resolve_unit.md
# jump_resolve_unit

Parametrised branch/jump resolution unit for the pipelined core. It sits beside the execute stage and receives jump/branch descriptors from the decoder. It tracks conditional branches through a configurable-depth resolution pipe and resolves JAL/JALR immediately. It drives the fetch redirect (`newPC`, `ctrlFetch`), the pipeline flush pulses and the decoder stall (`halt`). Compared with the fixed-depth generation, it adds configurable depths, squashing of wrong-path branches and optional misaligned-target trapping.

## Interface
- `XLEN`, 32: address/data width.
- `BR_DEPTH`, 2: cycles from branch issue to condition valid on `zero`/`bit_bus_C`; legal range ≥1.
- `HAZ_DEPTH`, 2: number of previous jump `rd` tags kept for the JALR RAW check; legal range ≥1.
- `REG_AW`, 6: register tag width.
- `PC_OFFSET`, 8: pipeline offset subtracted from `pc` for branch targets.
- `clock` in 1: clock (rising edge; flush pulses use the falling edge).
- `reset` in 1: synchronous, active-high.
- `new_jmp` in 1: a jump/branch descriptor is valid this cycle.
- `jmp_type` in 3: funct3 class. 010 = JAL, 011 = JALR, 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU.
- `jal_rs` in REG_AW: JALR source tag (0 = none/PC).
- `busJ` in XLEN: jump base (PC for JAL, rs1 for JALR).
- `rd` in REG_AW: jump destination tag.
- `bit_bus_C`, `zero` in 1: ALU sign/carry bit and zero flag for the branch at the pipe tail.
- `imm` in XLEN: sign-extended offset.
- `pc` in XLEN: current PC.
- `newPC` out XLEN: redirect target.
- `ctrlFetch` out 1: redirect valid (combinational).
- `reset_branch`, `reset_jal` out 1: registered flush pulses.
- `halt` out 1: stall decoder (combinational).
- `misalign_trap` out 1, `misalign_addr` out XLEN: only with the macro; otherwise tied to 0.

## Operation
- **Branch pipe:** BR_DEPTH entries, each {valid, type, target}. On issue of a non-jump descriptor, the target is computed at issue as `pc + imm - PC_OFFSET`, modulo 2^XLEN.
- **Condition at the tail entry:**
  - BEQ: `zero`.
  - BNE: `!zero`.
  - BLT/BLTU: `bit_bus_C == 1`.
  - BGE/BGEU: `bit_bus_C == 0`.
  - The resulting `br_taken` is combinational.
- **Squash (new behaviour):** on a clock edge where `br_taken` = 1, the following happens:
  - All younger pipe entries get valid cleared.
  - The descriptor presented that cycle is dropped.
  - The rd history is cleared to 0.
- **Jump:** `jmp_target = busJ + imm`. The jump resolves in its issue cycle unless `halt` is asserted.
- **halt = jump issued AND (any of the following):**
  - any pipe entry is valid (tail included);
  - `jal_rs` != 0 and `jal_rs` equals any history tag.
- **While halted:**
  - Nothing is enqueued.
  - The history shifts in 0.
  - The decoder re-presents the same descriptor.
- **rd history:** shifts in `rd` on every non-halted cycle that carries a jump. All other cycles shift in 0.
- **Redirect priority:**
  - If `br_taken`: `newPC` = tail target, `ctrlFetch` = 1.
  - Else if a jump is issued and not halted: `newPC` = jmp_target, `ctrlFetch` = 1.
  - Otherwise: `newPC` = tail target, `ctrlFetch` = 0.
  - A branch and a non-halted jump cannot coincide, because halt covers that case.

## Timing
- Branch redirect occurs exactly BR_DEPTH rising edges after issue; a jump redirect occurs in the issue cycle (0 latency).
- `reset_branch` and `reset_jal` are sampled on the falling edge:
  - `reset_branch` ← `br_taken`.
  - `reset_jal` ← jump issued AND NOT `halt`.
  - Each is a single-cycle pulse per event.
- **Reset:** when `reset` = 1 at an edge:
  - all pipe valids, types, targets and history tags ← 0;
  - `reset_branch`, `reset_jal`, `misalign_trap`, `misalign_addr` ← 0;
  - `halt`, `ctrlFetch` and `newPC` then evaluate to 0.
- Reset mid-operation discards all in-flight branches; no redirect is produced for them.
- Back-to-back branches may issue on every cycle. Each resolves independently unless an older one is taken, which squashes it.

## Configuration
- **`JRU_MISALIGN_TRAP_EN` defined:**
  - A selected redirect target with `[1:0]` != 0 forces `ctrlFetch` = 0 and suppresses the corresponding flush pulse.
  - It also sets `misalign_trap` for one cycle (registered at the next rising edge) and loads `misalign_addr` with the target.
  - Squash still applies for a misaligned taken branch.
- **Undefined:** bit 0 of the JALR target is cleared. No trap is raised, and the trap outputs are constant 0.

## Structure
- **Package `jru_pkg`:** funct3 constants (JAL, JALR, BEQ…BGEU), the pipe-entry struct typedef, and an `is_jump(funct3)` function.
- **Sub-module `jru_branch_pipe`:** the BR_DEPTH shift pipe, with enqueue, squash and tail outputs.
- The top level holds the rd history, halt logic, redirect mux and falling-edge pulse registers.

## Test plan
- **BEQ taken:** BEQ at pc = 0x100, imm = 0x20, BR_DEPTH = 2, `zero` = 1 at the tail → `ctrlFetch` = 1 two edges later, `newPC` = 0x118, one `reset_branch` pulse.
- **Squash:** BNE taken at the tail while a BLT sits in the younger stage with `bit_bus_C` = 1 → only one redirect; the BLT never redirects.
- **JALR RAW hazard:** JAL rd = 5, then JALR `jal_rs` = 5, busJ = 0x400, imm = 4 → `halt` = 1 for 2 cycles; then `newPC` = 0x404 with a `reset_jal` pulse.
- **Jump behind branch:** JAL issued while a BGE is in flight → `halt` until the pipe is empty; the branch resolves first.
- **Misaligned target:** JALR target 0x402 with macro defined → `misalign_trap` pulse, `misalign_addr` = 0x402, no redirect. Without the macro → `newPC` = 0x402.
- **Reset mid-flight:** assert reset with 2 valid branches → no redirect; all outputs 0 on the next cycle.
